// File: rtl/text_pkg.sv
// Shared constants, FSM state encoding and the printable-byte filter for the text dump transmitter.
// Optional CR/LF line endings are enabled by defining TEXT_DUMP_CRLF_EN.
package text_pkg;

  localparam logic [7:0] ASCII_CR  = 8'h0D;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_DOT = 8'h2E;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  localparam logic [4:0] COL_FIRST = 5'd24;
  localparam logic [4:0] COL_LAST  = 5'd31;
  localparam logic [1:0] ROW_LAST  = 2'd3;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t ADDR   = 3'd1;
  localparam state_t LATCH  = 3'd2;
  localparam state_t SEND   = 3'd3;
  localparam state_t FIN    = 3'd4;
`ifdef TEXT_DUMP_CRLF_EN
  localparam state_t EOL_CR = 3'd5;
  localparam state_t EOL_LF = 3'd6;
`endif

  // Control characters and DEL would upset a terminal, so they go out as '.'.
  function automatic logic [7:0] printable(input logic [7:0] b);
    return ((b < PRINT_MIN) || (b > PRINT_MAX)) ? ASCII_DOT : b;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte serializer: start bit, eight data bits LSB first, one stop bit.
// A byte is taken when valid && ready; ready is high only while the line is idle.
module uart_tx_byte #(
  parameter int BIT_CLKS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BIT_CLKS - 1);
  localparam logic [3:0]       LAST_DATA = 4'd8;
  localparam logic [3:0]       STOP_BIT  = 4'd9;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             active_q, active_d;
  logic             tx_q, tx_d;

  assign ready = !active_q;
  assign tx    = tx_q;

  // bit_q: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  always_comb begin
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    active_d = active_q;
    tx_d     = tx_q;
    if (!active_q) begin
      if (valid) begin
        active_d = 1'b1;
        shift_d  = data;
        bit_d    = '0;
        cnt_d    = '0;
        tx_d     = 1'b0;
      end
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      if (bit_q == STOP_BIT) begin
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
        if (bit_q == LAST_DATA) begin
          tx_d = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      active_q <= active_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/text_dump_tx.sv
// Dumps columns 24..31 of a 4-row text buffer over a UART, one row per line.
// Define TEXT_DUMP_CRLF_EN to terminate each row with CR LF (40 bytes per dump instead of 32).
module text_dump_tx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [1:0] ram_row,
  output logic [4:0] ram_col,
  input  logic [7:0] ram_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  import text_pkg::*;

  localparam int BIT_CLKS = CLK_HZ / BAUD;

  state_t     state_q, state_d;
  logic [1:0] row_q, row_d;
  logic [4:0] col_q, col_d;
  logic [7:0] byte_q, byte_d;
  logic       sent_q, sent_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       ser_valid;
  logic       ser_ready;
  logic [7:0] ser_data;

  assign ram_row = row_q;
  assign ram_col = col_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef TEXT_DUMP_CRLF_EN
  assign ser_valid = ((state_q == SEND) || (state_q == EOL_CR) || (state_q == EOL_LF)) && !sent_q;
  assign ser_data  = (state_q == SEND)   ? byte_q :
                     (state_q == EOL_CR) ? ASCII_CR : ASCII_LF;
`else
  assign ser_valid = (state_q == SEND) && !sent_q;
  assign ser_data  = byte_q;
`endif

  uart_tx_byte #(
    .BIT_CLKS(BIT_CLKS)
  ) u_uart (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  (ser_valid),
    .data   (ser_data),
    .ready  (ser_ready),
    .tx     (tx)
  );

  // The row/col registers double as the read address: they only move on the
  // transition into ADDR, so the buffer sees a stable address through LATCH.
  // sent_q separates "byte handed over" from "line idle again" in each send state.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    byte_d  = byte_q;
    sent_d  = sent_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          row_d   = '0;
          col_d   = COL_FIRST;
          busy_d  = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        state_d = LATCH;
      end
      LATCH: begin
        byte_d  = printable(ram_data);
        sent_d  = 1'b0;
        state_d = SEND;
      end
      SEND: begin
        if (!sent_q) begin
          if (ser_ready) sent_d = 1'b1;
        end else if (ser_ready) begin
          sent_d = 1'b0;
          if (col_q != COL_LAST) begin
            col_d   = col_q + 5'd1;
            state_d = ADDR;
          end else begin
`ifdef TEXT_DUMP_CRLF_EN
            state_d = EOL_CR;
`else
            if (row_q == ROW_LAST) begin
              state_d = FIN;
            end else begin
              row_d   = row_q + 2'd1;
              col_d   = COL_FIRST;
              state_d = ADDR;
            end
`endif
          end
        end
      end
`ifdef TEXT_DUMP_CRLF_EN
      EOL_CR: begin
        if (!sent_q) begin
          if (ser_ready) sent_d = 1'b1;
        end else if (ser_ready) begin
          sent_d  = 1'b0;
          state_d = EOL_LF;
        end
      end
      EOL_LF: begin
        if (!sent_q) begin
          if (ser_ready) sent_d = 1'b1;
        end else if (ser_ready) begin
          sent_d = 1'b0;
          if (row_q == ROW_LAST) begin
            state_d = FIN;
          end else begin
            row_d   = row_q + 2'd1;
            col_d   = COL_FIRST;
            state_d = ADDR;
          end
        end
      end
`endif
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      byte_q  <= '0;
      sent_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      byte_q  <= byte_d;
      sent_q  <= sent_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_text_dump_tx.sv
// Self-checking bench for text_dump_tx at 16 clocks per bit; follows TEXT_DUMP_CRLF_EN
// to decide whether rows end in CR LF.
module tb_text_dump_tx;

  localparam int BIT_CLKS = 16;
  localparam int FRAME    = 10 * BIT_CLKS;
`ifdef TEXT_DUMP_CRLF_EN
  localparam int EXP_N   = 40;
  localparam int EXP_EOL = 8;
`else
  localparam int EXP_N   = 32;
  localparam int EXP_EOL = 0;
`endif
  localparam int ROW_BYTES = EXP_N / 4;
  localparam int TIMEOUT   = EXP_N * (FRAME + 10) + 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [1:0] ram_row;
  logic [4:0] ram_col;
  logic [7:0] ram_data;
  logic       tx;
  logic       busy;
  logic       done;

  logic [7:0] mem [0:3][0:31];
  logic [7:0] exp_q[$];
  logic [7:0] rx_log[$];

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int done_busy_bad = 0;
  int max_gap = 0;
  int idle_run = 0;
  int frames_started = 0;

  logic       in_frame = 1'b0;
  int         fcyc = 0;
  int         bad_cyc = 0;
  logic [7:0] cur_exp = 8'h00;
  logic [7:0] got = 8'h00;
  logic       cur_extra = 1'b0;
  logic       prev_busy = 1'b0;

  text_dump_tx #(
    .CLK_HZ(16),
    .BAUD  (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .ram_row (ram_row),
    .ram_col (ram_col),
    .ram_data(ram_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Synchronous text buffer: data appears one clock after the address.
  always @(posedge clk) ram_data <= mem[ram_row][ram_col];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    return (i < rx_log.size()) ? rx_log[i] : 8'hFF;
  endfunction

  // Reference byte stream: scan order, printable substitution, optional line endings.
  task automatic build_expected();
    logic [7:0] b;
    exp_q.delete();
    for (int r = 0; r < 4; r++) begin
      for (int c = 24; c < 32; c++) begin
        b = mem[r][c];
        exp_q.push_back((b < 8'h20 || b > 8'h7E) ? 8'h2E : b);
      end
`ifdef TEXT_DUMP_CRLF_EN
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
`endif
    end
  endtask

  // Line monitor: every sample inside a frame must equal the bit the expected byte dictates.
  initial begin
    int   bidx;
    logic ebit;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_frame = 1'b0;
        idle_run = 0;
      end else begin
        if (done === 1'b1) begin
          done_cnt++;
          if (busy !== 1'b0 || prev_busy !== 1'b1) done_busy_bad++;
        end
        if (!in_frame) begin
          if (tx === 1'b0) begin
            in_frame = 1'b1;
            fcyc     = 0;
            bad_cyc  = 0;
            got      = 8'h00;
            frames_started++;
            if (rx_log.size() > 0 && idle_run > max_gap) max_gap = idle_run;
            idle_run = 0;
            if (exp_q.size() > 0) begin
              cur_exp   = exp_q.pop_front();
              cur_extra = 1'b0;
            end else begin
              cur_exp   = 8'h00;
              cur_extra = 1'b1;
            end
          end else if (busy === 1'b1) begin
            idle_run++;
          end
        end
        if (in_frame) begin
          bidx = fcyc / BIT_CLKS;
          if (bidx == 0)      ebit = 1'b0;
          else if (bidx == 9) ebit = 1'b1;
          else                ebit = cur_exp[bidx-1];
          if (tx !== ebit) bad_cyc++;
          if ((fcyc % BIT_CLKS) == BIT_CLKS / 2 && bidx >= 1 && bidx <= 8) got[bidx-1] = tx;
          fcyc++;
          if (fcyc == FRAME) begin
            in_frame = 1'b0;
            rx_log.push_back(got);
            n_vec++;
            if (cur_extra || bad_cyc != 0 || got !== cur_exp) begin
              n_bad++;
              $display("[TB] FAIL frame%0d: got byte 0x%02h (%0d off-pattern cycles, unexpected=%0b), expected byte 0x%02h",
                       rx_log.size() - 1, got, bad_cyc, cur_extra, cur_exp);
            end
          end
        end
      end
      prev_busy = busy;
    end
  end

  task automatic applyStimulus(input int mid_start, input bit timing);
    int cyc;
    bit pulsed;
    build_expected();
    rx_log.delete();
    done_cnt      = 0;
    done_busy_bad = 0;
    max_gap       = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (timing) begin
      check("busy_T1", 32'(busy), 32'd1);
      @(negedge clk);
      check("ram_row_T2", 32'(ram_row), 32'd0);
      check("ram_col_T2", 32'(ram_col), 32'd24);
      @(negedge clk);
      check("tx_high_T3", 32'(tx), 32'd1);
      @(negedge clk);
      check("tx_low_T4", 32'(tx), 32'd0);
    end
    cyc    = 0;
    pulsed = 1'b0;
    while (done_cnt == 0 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (mid_start >= 0 && !pulsed && rx_log.size() >= mid_start) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("done_within_budget", 32'(cyc < TIMEOUT), 32'd1);
    repeat (200) @(negedge clk);
  endtask

  task automatic checkOutput();
    int eol;
    eol = 0;
    foreach (rx_log[i]) if (rx_log[i] == 8'h0D || rx_log[i] == 8'h0A) eol++;
    check("byte_count", 32'(rx_log.size()), 32'(EXP_N));
    check("model_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_falls_with_done", 32'(done_busy_bad), 32'd0);
    check("busy_after_dump", 32'(busy), 32'd0);
    check("max_idle_gap_le4", 32'(max_gap <= 4), 32'd1);
    check("eol_bytes", 32'(eol), 32'(EXP_EOL));
  endtask

  initial begin
    int cyc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 32; c++) mem[r][c] = 8'h41;
    mem[0][24] = 8'h48; mem[0][25] = 8'h45; mem[0][26] = 8'h4C; mem[0][27] = 8'h4C;
    mem[0][28] = 8'h4F; mem[0][29] = 8'h31; mem[0][30] = 8'h32; mem[0][31] = 8'h33;

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ram_row", 32'(ram_row), 32'd0);
    check("reset_ram_col", 32'(ram_col), 32'd0);
    #2 reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] dump 1: HELLO123 row plus first-frame timing");
    applyStimulus(-1, 1'b1);
    checkOutput();
    check("pin_byte0_H", 32'(rx_at(0)), 32'h48);
    check("pin_byte4_O", 32'(rx_at(4)), 32'h4F);
    check("pin_byte7_3", 32'(rx_at(7)), 32'h33);
`ifdef TEXT_DUMP_CRLF_EN
    check("pin_byte8_CR", 32'(rx_at(8)), 32'h0D);
    check("pin_byte9_LF", 32'(rx_at(9)), 32'h0A);
    check("pin_byte10_A", 32'(rx_at(10)), 32'h41);
`else
    check("pin_byte8_A", 32'(rx_at(8)), 32'h41);
`endif

    $display("[TB] dump 2: non-printable substitution");
    mem[1][26] = 8'h07;
    mem[2][24] = 8'h7F;
    mem[3][31] = 8'h20;
    mem[0][31] = 8'h7E;
    applyStimulus(-1, 1'b0);
    checkOutput();
    check("pin_bel_to_dot", 32'(rx_at(1 * ROW_BYTES + 2)), 32'h2E);
    check("pin_del_to_dot", 32'(rx_at(2 * ROW_BYTES + 0)), 32'h2E);
    check("pin_space_kept", 32'(rx_at(3 * ROW_BYTES + 7)), 32'h20);
    check("pin_tilde_kept", 32'(rx_at(0 * ROW_BYTES + 7)), 32'h7E);

    $display("[TB] dump 3: start while busy is ignored");
    applyStimulus(5, 1'b0);
    checkOutput();

    $display("[TB] dump 4: reset during byte 10");
    build_expected();
    rx_log.delete();
    done_cnt       = 0;
    frames_started = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (frames_started < 11 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_byte10", 32'(cyc < TIMEOUT), 32'd1);
    repeat (40) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx_high", 32'(tx), 32'd1);
    check("abort_busy_low", 32'(busy), 32'd0);
    check("abort_done_low", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    #2 reset_n = 1'b1;
    exp_q.delete();
    rx_log.delete();
    repeat (5) @(negedge clk);
    check("abort_line_idle", 32'(tx), 32'd1);
    check("abort_still_idle", 32'(busy), 32'd0);

    $display("[TB] dump 5: full dump after abort");
    applyStimulus(-1, 1'b0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
